seven_seg_scan: RTL

Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one `seven_seg` decoder. It holds a multi-digit hex value and steps through the digits in order. For each digit it presents that digit's nibble to the decoder and enables the matching anode, with an all-off dead gap between digits to suppress ghosting. It sits between the ALU/result registers and the board display pins. New values are loaded with a one-cycle strobe and applied only at frame boundaries, so the display never shows a torn value.

---
 rtl/seven_seg_scan_if.sv | 26 ++
 rtl/seven_seg_scan.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for the seven-segment scan controller.
// Master drives load/value/blanking; slave returns scan outputs.
interface seven_seg_scan_if #(
    parameter int N_DIGITS = 4
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                    load;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     blank_mask;
    logic                    lzs;
    logic [3:0]              nibble;
    logic [N_DIGITS-1:0]     an;
    logic [IW-1:0]           digit_idx;
    logic                    frame_done;

    modport master (
        output load, value, blank_mask, lzs,
        input  nibble, an, digit_idx, frame_done
    );

    modport slave (
        input  load, value, blank_mask, lzs,
        output nibble, an, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for common-anode 7-seg digits.
// Values are double-buffered and swapped only at frame boundaries.
module seven_seg_scan #(
    parameter int N_DIGITS   = 4,
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);
    localparam int VW   = 4 * N_DIGITS;
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    typedef enum logic {
        S_GAP = 1'b0,
        S_ON  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [VW-1:0]       shadow_q, shadow_d;
    logic [VW-1:0]       active_q, active_d;
    logic                pending_q, pending_d;
    logic [3:0]          nibble_q, nibble_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                leave_on;
    logic                commit;
    logic [N_DIGITS-1:0] dark;

    // Phase sequencing: count out gap/on time, step digit on ON exit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        leave_on = 1'b0;
        unique case (state_q)
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d  = S_GAP;
                    cnt_d    = '0;
                    leave_on = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
        endcase
    end

    // Value buffering: capture loads, commit at end of the last digit
    always_comb begin
        commit    = leave_on && (idx_q == IDX_LAST) && pending_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end
        if (commit) begin
            // A load landing on the commit edge is newer than shadow
            active_d  = bus.load ? bus.value : shadow_q;
            pending_d = 1'b0;
        end
    end

    // Per-digit darkness: explicit mask or leading-zero suppression
    always_comb begin
        dark = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            dark[i] = bus.blank_mask[i]
                    | (bus.lzs && (i != 0)
                       && ((active_q >> (4 * i)) == '0));
        end
    end

    // Next registered outputs: anode, decoder nibble, commit pulse
    always_comb begin
        an_d = '1;
        if ((state_d == S_ON) && !dark[idx_d]) begin
            an_d[idx_d] = 1'b0;
        end
        nibble_d = nibble_q;
        if (leave_on) begin
            nibble_d = active_d[4 * idx_d +: 4];
        end
        frame_done_d = commit;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= '0;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.nibble     = nibble_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;

endmodule
